// File: rtl/tap_pkg.sv
// Shared TAP definitions: 4-bit state encoding (IEEE 1149.1 values) and
// the fixed instruction codes. BYPASS is all ones at whatever IR width is used.
package tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  localparam int unsigned INS_EXTEST = 0;
  localparam int unsigned INS_SAMPLE = 1;
  localparam int unsigned INS_IDCODE = 2;
  localparam int unsigned IDCODE_W   = 32;

endpackage

// File: rtl/tap_ctrl_if.sv
// JTAG pins plus the boundary-cell control bundle of the TAP controller.
interface tap_ctrl_if #(
  parameter int IR_W = 4
);
  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic            bsr_tdi;
  logic            bsr_tdo;
  logic            mode;
  logic            shift_dr;
  logic            clk_dr;
  logic            update_dr;
  logic [IR_W-1:0] ir_out;
  logic [3:0]      state_o;

  modport master (
    output tms, tdi, bsr_tdo,
    input  tdo, tdo_en, bsr_tdi, mode, shift_dr, clk_dr, update_dr, ir_out, state_o
  );

  modport slave (
    input  tms, tdi, bsr_tdo,
    output tdo, tdo_en, bsr_tdi, mode, shift_dr, clk_dr, update_dr, ir_out, state_o
  );
endinterface

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine; the state register is the output.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       iclk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_q;

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:      state_q <= tms ? TLR      : RTI;
        RTI:      state_q <= tms ? SEL_DR   : RTI;
        SEL_DR:   state_q <= tms ? SEL_IR   : CAP_DR;
        CAP_DR:   state_q <= tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_q <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_q <= tms ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_q <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_q <= tms ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_q <= tms ? SEL_DR   : RTI;
        SEL_IR:   state_q <= tms ? TLR      : CAP_IR;
        CAP_IR:   state_q <= tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_q <= tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_q <= tms ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_q <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_q <= tms ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_q <= tms ? SEL_DR   : RTI;
        default:  state_q <= TLR;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller: instruction register, IDCODE and BYPASS data registers,
// and boundary-cell control decoded from the registered state and instruction.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic     iclk,
  input  logic     rst,
  tap_ctrl_if.slave bus
);

  localparam logic [IR_W-1:0] IR_EXTEST = IR_W'(INS_EXTEST);
  localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(INS_SAMPLE);
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(INS_IDCODE);

  tap_state_e state;

  logic [IR_W-1:0]     ir_sr_q, ir_sr_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic                byp_q, byp_d;
  logic [IDCODE_W-1:0] id_q, id_d;
  logic                sel_bsr, sel_id, sel_byp;

  tap_fsm u_fsm (
    .iclk  (iclk),
    .rst   (rst),
    .tms   (bus.tms),
    .state (state)
  );

  // Undefined codes fall through to BYPASS together with the all-ones code.
  assign sel_bsr = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
  assign sel_id  = (ir_q == IR_IDCODE);
  assign sel_byp = !sel_bsr && !sel_id;

  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    byp_d   = byp_q;
    id_d    = id_q;
    case (state)
      TLR:      ir_d    = IR_IDCODE;
      CAP_IR:   ir_sr_d = IR_W'(1);
      SHIFT_IR: ir_sr_d = {bus.tdi, ir_sr_q[IR_W-1:1]};
      UPD_IR:   ir_d    = ir_sr_q;
      CAP_DR: begin
        if (sel_id)  id_d  = IDCODE;
        if (sel_byp) byp_d = 1'b0;
      end
      SHIFT_DR: begin
        if (sel_id)  id_d  = {bus.tdi, id_q[IDCODE_W-1:1]};
        if (sel_byp) byp_d = bus.tdi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      ir_sr_q <= '0;
      ir_q    <= IR_IDCODE;
      byp_q   <= 1'b0;
      id_q    <= IDCODE;
    end else begin
      ir_sr_q <= ir_sr_d;
      ir_q    <= ir_d;
      byp_q   <= byp_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    bus.tdo = 1'b0;
    case (state)
      SHIFT_IR: bus.tdo = ir_sr_q[0];
      SHIFT_DR: bus.tdo = sel_bsr ? bus.bsr_tdo : (sel_id ? id_q[0] : byp_q);
      default:  ;
    endcase
  end

  // Decodes of the current state: boundary cells act on the edge leaving it.
  assign bus.tdo_en    = (state == SHIFT_DR) || (state == SHIFT_IR);
  assign bus.shift_dr  = (state == SHIFT_DR);
  assign bus.clk_dr    = sel_bsr && ((state == CAP_DR) || (state == SHIFT_DR));
  assign bus.update_dr = sel_bsr && (state == UPD_DR);
  assign bus.mode      = (ir_q == IR_EXTEST);
  assign bus.bsr_tdi   = bus.tdi;
  assign bus.ir_out    = ir_q;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_tap_ctrl.sv
// Bench for tap_ctrl: directed JTAG scenarios followed by random tms/tdi/rst,
// every cycle compared against a queue-based model of the TAP registers.
module tb_tap_ctrl;
  import tap_pkg::*;

  localparam int          IR_W = 4;
  localparam logic [31:0] IDC  = 32'h1000_0001;

  logic iclk = 1'b0;
  logic rst  = 1'b1;
  always #5 iclk = ~iclk;

  tap_ctrl_if #(.IR_W(IR_W)) bus ();

  tap_ctrl #(.IR_W(IR_W), .IDCODE(IDC)) dut (
    .iclk (iclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: transition table, instruction as an integer, and the
  // IR / selected DR held as bit queues (front = bit nearest tdo).
  tap_state_e nxt0 [16];
  tap_state_e nxt1 [16];
  tap_state_e m_st;
  int         m_ir;
  bit         m_irq [$];
  bit         m_drq [$];

  logic obs_tdo;
  int   c_shift, c_clksh, c_clk, c_upd;

  task automatic set_tr(tap_state_e s, tap_state_e on0, tap_state_e on1);
    nxt0[int'(s)] = on0;
    nxt1[int'(s)] = on1;
  endtask

  function automatic bit m_bsr();
    return (m_ir == 0) || (m_ir == 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit sh_dr;
    bit sh_ir;
    bit e_tdo;
    sh_dr = (m_st == SHIFT_DR);
    sh_ir = (m_st == SHIFT_IR);
    e_tdo = 1'b0;
    if (sh_ir)      e_tdo = m_irq[0];
    else if (sh_dr) e_tdo = m_bsr() ? bus.bsr_tdo : m_drq[0];
    chk("state",     32'(bus.state_o),   32'(m_st));
    chk("ir_out",    32'(bus.ir_out),    32'(m_ir));
    chk("tdo",       32'(bus.tdo),       32'(e_tdo));
    chk("tdo_en",    32'(bus.tdo_en),    32'(sh_dr | sh_ir));
    chk("shift_dr",  32'(bus.shift_dr),  32'(sh_dr));
    chk("clk_dr",    32'(bus.clk_dr),    32'(m_bsr() && (m_st == CAP_DR || sh_dr)));
    chk("update_dr", 32'(bus.update_dr), 32'(m_bsr() && (m_st == UPD_DR)));
    chk("mode",      32'(bus.mode),      32'(m_ir == 0));
    chk("bsr_tdi",   32'(bus.bsr_tdi),   32'(bus.tdi));
  endtask

  task automatic m_update(bit t, bit d, bit r);
    logic [31:0] idv;
    idv = IDC;
    if (r) begin
      m_st = TLR;
      m_ir = 2;
      m_irq.delete();
      for (int i = 0; i < IR_W; i++) m_irq.push_back(1'b0);
      return;
    end
    case (m_st)
      TLR:    m_ir = 2;
      CAP_IR: begin
        m_irq.delete();
        m_irq.push_back(1'b1);
        for (int i = 1; i < IR_W; i++) m_irq.push_back(1'b0);
      end
      SHIFT_IR: begin
        void'(m_irq.pop_front());
        m_irq.push_back(d);
      end
      UPD_IR: begin
        m_ir = 0;
        for (int i = 0; i < IR_W; i++) if (m_irq[i]) m_ir += (1 << i);
      end
      CAP_DR: begin
        if (m_ir == 2) begin
          m_drq.delete();
          for (int i = 0; i < 32; i++) m_drq.push_back(idv[i]);
        end else if (!m_bsr()) begin
          m_drq.delete();
          m_drq.push_back(1'b0);
        end
      end
      SHIFT_DR: begin
        if (!m_bsr()) begin
          void'(m_drq.pop_front());
          m_drq.push_back(d);
        end
      end
      default: ;
    endcase
    m_st = t ? nxt1[int'(m_st)] : nxt0[int'(m_st)];
  endtask

  // One TCK: drive on the falling edge, sample 1 ns later, advance model on the rise.
  task automatic step(bit t, bit d, bit r = 1'b0, bit do_chk = 1'b1);
    @(negedge iclk);
    bus.tms     = t;
    bus.tdi     = d;
    bus.bsr_tdo = 1'($urandom);
    rst         = r;
    #1;
    if (do_chk) check_outputs();
    obs_tdo = bus.tdo;
    c_shift += (bus.shift_dr === 1'b1) ? 1 : 0;
    c_clksh += (bus.shift_dr === 1'b1 && bus.clk_dr === 1'b1) ? 1 : 0;
    c_clk   += (bus.clk_dr === 1'b1) ? 1 : 0;
    c_upd   += (bus.update_dr === 1'b1) ? 1 : 0;
    @(posedge iclk);
    m_update(t, d, r);
  endtask

  task automatic clr_counts();
    c_shift = 0;
    c_clksh = 0;
    c_clk   = 0;
    c_upd   = 0;
  endtask

  // From TLR or RTI: load an instruction and end in RTI.
  task automatic load_ir(logic [IR_W-1:0] v);
    step(0, 0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < IR_W; i++) step(i == IR_W - 1, v[i]);
    step(1, 0);
    step(0, 0);
  endtask

  initial begin
    logic [31:0]     cap;
    logic [2:0]      bseq;
    logic [IR_W-1:0] irv;
    logic [IR_W-1:0] ircap;

    set_tr(TLR,      RTI,      TLR);
    set_tr(RTI,      RTI,      SEL_DR);
    set_tr(SEL_DR,   CAP_DR,   SEL_IR);
    set_tr(CAP_DR,   SHIFT_DR, EXIT1_DR);
    set_tr(SHIFT_DR, SHIFT_DR, EXIT1_DR);
    set_tr(EXIT1_DR, PAUSE_DR, UPD_DR);
    set_tr(PAUSE_DR, PAUSE_DR, EXIT2_DR);
    set_tr(EXIT2_DR, SHIFT_DR, UPD_DR);
    set_tr(UPD_DR,   RTI,      SEL_DR);
    set_tr(SEL_IR,   CAP_IR,   TLR);
    set_tr(CAP_IR,   SHIFT_IR, EXIT1_IR);
    set_tr(SHIFT_IR, SHIFT_IR, EXIT1_IR);
    set_tr(EXIT1_IR, PAUSE_IR, UPD_IR);
    set_tr(PAUSE_IR, PAUSE_IR, EXIT2_IR);
    set_tr(EXIT2_IR, SHIFT_IR, UPD_IR);
    set_tr(UPD_IR,   RTI,      SEL_DR);
    m_drq.push_back(1'b0);
    for (int i = 0; i < IR_W; i++) m_irq.push_back(1'b0);
    m_st = TLR;
    m_ir = 2;
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    bus.bsr_tdo = 1'b0;
    clr_counts();

    // Reset, then five tms=1 cycles
    step(1, 0, 1, 0);
    step(1, 0, 1);
    repeat (5) step(1, 0);
    #1;
    chk("rst_state", 32'(bus.state_o), 32'(TLR));
    chk("rst_ir", 32'(bus.ir_out), 32'h2);
    chk("rst_enables", 32'({bus.tdo, bus.tdo_en, bus.mode, bus.shift_dr, bus.clk_dr, bus.update_dr}), 32'h0);

    // IDCODE read-out, LSB first
    step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    cap = '0;
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'($urandom));
      cap[i] = obs_tdo;
    end
    chk("idcode_shift", cap, IDC);
    step(1, 0);
    step(0, 0);

    // EXTEST with an 8-bit boundary scan
    load_ir(4'h0);
    #1;
    chk("ir_extest", 32'(bus.ir_out), 32'h0);
    chk("extest_mode", 32'(bus.mode), 32'h1);
    clr_counts();
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 8; i++) step(i == 7, 1'($urandom));
    step(1, 0);
    step(0, 0);
    chk("extest_shift_cycles", 32'(c_shift), 32'd8);
    chk("extest_clk_in_shift", 32'(c_clksh), 32'd8);
    chk("extest_update_cycles", 32'(c_upd), 32'd1);

    // Undefined code behaves as one-bit bypass
    load_ir(4'h5);
    clr_counts();
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1); bseq[0] = obs_tdo;
    step(0, 0); bseq[1] = obs_tdo;
    step(1, 1); bseq[2] = obs_tdo;
    step(1, 0);
    step(0, 0);
    chk("bypass_delay", 32'(bseq), 32'b010);
    chk("bypass_no_clk_dr", 32'(c_clk), 32'd0);

    // IR capture pattern and a pause in the middle of the IR shift
    irv = IR_W'($urandom);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, irv[0]); ircap[0] = obs_tdo;
    step(0, irv[1]); ircap[1] = obs_tdo;
    step(1, irv[2]); ircap[2] = obs_tdo;
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    step(1, irv[3]); ircap[3] = obs_tdo;
    step(1, 0);
    step(0, 0);
    #1;
    chk("ir_capture", 32'(ircap), 32'b0001);
    chk("ir_after_pause", 32'(bus.ir_out), 32'(irv));

    // Reset in the middle of an IR shift
    load_ir(4'h0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    step(0, 0, 1);
    #1;
    chk("midshift_rst_state", 32'(bus.state_o), 32'(TLR));
    chk("midshift_rst_ir", 32'(bus.ir_out), 32'h2);
    chk("midshift_rst_tdo_en", 32'(bus.tdo_en), 32'h0);

    // Random traffic with occasional reset
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
